// File: rtl/tmds_pkg.sv
// Shared TMDS period types, fixed symbol tables and the stage-1 transition
// minimising helpers used by every lane.
package tmds_pkg;
    typedef enum logic [1:0] {
        CTRL    = 2'd0,
        VIDEO   = 2'd1,
        VGUARD  = 2'd2,
        DISLAND = 2'd3
    } tmds_mode_t;

    localparam logic [9:0] CTL_CODE [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    localparam logic [9:0] TERC4_CODE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    localparam logic [9:0] VGUARD_A = 10'b1011001100;
    localparam logic [9:0] VGUARD_B = 10'b0100110011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    // XOR/XNOR chain selection picks whichever yields fewer transitions.
    function automatic logic [8:0] qm_encode(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8]     = ~use_xnor;
        return q;
    endfunction
endpackage

// File: rtl/tmds_ch_enc.sv
// One TMDS lane: stage 1 registers the transition-minimised word, stage 2
// applies DC balancing (VIDEO) or the fixed period codes and owns cnt.
module tmds_ch_enc
    import tmds_pkg::*;
#(
    parameter int CH_IDX = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [1:0] mode,
    input  logic [7:0] d,
    input  logic [1:0] ctl,
    input  logic [3:0] terc4,
    output logic [9:0] tmds
);
    logic [8:0]        qm;
    logic [8:0]        s1_qm;
    logic [3:0]        s1_nq;
    tmds_mode_t        s1_mode;
    logic [1:0]        s1_ctl;
    logic [3:0]        s1_terc4;
    logic signed [4:0] cnt;
    logic signed [4:0] cnt_nxt;
    logic signed [4:0] diff;
    logic [9:0]        sym;

    assign qm = qm_encode(d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_qm    <= '0;
            s1_nq    <= '0;
            s1_mode  <= CTRL;
            s1_ctl   <= '0;
            s1_terc4 <= '0;
        end else if (ce) begin
            s1_qm    <= qm;
            s1_nq    <= popcount8(qm[7:0]);
            s1_mode  <= tmds_mode_t'(mode);
            s1_ctl   <= ctl;
            s1_terc4 <= terc4;
        end
    end

    // diff = ones - zeros of q_m[7:0]; modulo-32 arithmetic keeps the sign right.
    always_comb begin
        diff    = {s1_nq, 1'b0} - 5'd8;
        sym     = CTL_CODE[s1_ctl];
        cnt_nxt = '0;
        case (s1_mode)
            VIDEO: begin
                if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
                    sym     = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
                    cnt_nxt = s1_qm[8] ? (cnt + diff) : (cnt - diff);
                end else if (((cnt > 5'sd0) && (diff > 5'sd0)) ||
                             ((cnt < 5'sd0) && (diff < 5'sd0))) begin
                    sym     = {1'b1, s1_qm[8], ~s1_qm[7:0]};
                    cnt_nxt = cnt + $signed({3'b000, s1_qm[8], 1'b0}) - diff;
                end else begin
                    sym     = {1'b0, s1_qm[8], s1_qm[7:0]};
                    cnt_nxt = cnt + diff - $signed({3'b000, ~s1_qm[8], 1'b0});
                end
            end
            VGUARD:  sym = (CH_IDX % 3 == 1) ? VGUARD_B : VGUARD_A;
            DISLAND: sym = TERC4_CODE[s1_terc4];
            CTRL:    sym = CTL_CODE[s1_ctl];
            default: sym = CTL_CODE[s1_ctl];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmds <= CTL_CODE[0];
            cnt  <= '0;
        end else if (ce) begin
            tmds <= sym;
            cnt  <= cnt_nxt;
        end
    end
endmodule

// File: rtl/tmds_encoder_mc.sv
// Multi-channel TMDS encoder: NUM_CH independent lanes sharing mode/ce, plus
// a two-deep fill flag that marks when the pipeline holds real symbols.
module tmds_encoder_mc
    import tmds_pkg::*;
#(
    parameter int NUM_CH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [1:0]             mode,
    input  logic [8*NUM_CH-1:0]    d_in,
    input  logic [2*NUM_CH-1:0]    ctl,
    input  logic [4*NUM_CH-1:0]    terc4,
    output logic [10*NUM_CH-1:0]   tmds_out,
    output logic                   out_valid
);
    logic s1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            s1_valid  <= 1'b1;
            out_valid <= s1_valid;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tmds_ch_enc #(
            .CH_IDX (k)
        ) u_enc (
            .clk   (clk),
            .rst   (rst),
            .ce    (ce),
            .mode  (mode),
            .d     (d_in[8*k +: 8]),
            .ctl   (ctl[2*k +: 2]),
            .terc4 (terc4[4*k +: 4]),
            .tmds  (tmds_out[10*k +: 10])
        );
    end
endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Directed and model-checked bench for tmds_encoder_mc with three lanes.
module tb_tmds_encoder_mc;
    localparam int NUM_CH = 3;
    localparam int N_RND  = 10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [1:0]  mode;
    logic [23:0] d_in;
    logic [5:0]  ctl;
    logic [11:0] terc4;
    logic [29:0] tmds_out;
    logic        out_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] ctl_ref [4] = '{
        10'h354, 10'h0AB, 10'h154, 10'h2AB
    };
    logic [9:0] terc4_ref [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    // Directed single-byte stream (same byte on every lane), hand-encoded.
    localparam int N_DIR = 13;
    logic [1:0] dv_m [N_DIR] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                                 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1};
    logic [7:0] dv_d [N_DIR] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h10, 8'h55,
                                 8'hAA, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
    logic [9:0] dv_e [N_DIR] = '{10'h354, 10'h100, 10'h3FF, 10'h200, 10'h0FF, 10'h1F0,
                                 10'h133, 10'h233, 10'h1FF, 10'h300, 10'h100, 10'h354,
                                 10'h100};

    int          cnt_m [NUM_CH];
    int          cn;
    logic [29:0] e_cur, e_prev, e_out;
    logic [1:0]  r_m;
    logic [23:0] r_d;
    logic [5:0]  r_c;
    logic [11:0] r_t;
    logic [3:0]  n0, n1, n2;

    tmds_encoder_mc #(.NUM_CH(NUM_CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .mode      (mode),
        .d_in      (d_in),
        .ctl       (ctl),
        .terc4     (terc4),
        .tmds_out  (tmds_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [23:0] d, input logic [5:0] c,
                         input logic [11:0] t);
        mode  = m;
        d_in  = d;
        ctl   = c;
        terc4 = t;
    endtask

    // Reference lane: q_m written as prefix parity, inverted on odd bits for XNOR.
    function automatic logic [9:0] ref_sym(input int ch, input logic [1:0] m, input logic [7:0] d,
                                           input logic [1:0] c, input logic [3:0] t,
                                           input int cnt_in, output int cnt_out);
        int         n_ones, ones, diff, cc;
        bit         xn, p, q8;
        logic [7:0] q;
        logic [9:0] s;
        cnt_out = 0;
        case (m)
            2'd0: s = ctl_ref[c];
            2'd2: s = (ch % 3 == 1) ? 10'b0100110011 : 10'b1011001100;
            2'd3: s = terc4_ref[t];
            default: begin
                n_ones = $countones(d);
                xn     = (n_ones > 4) || (n_ones == 4 && d[0] == 1'b0);
                p      = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    p    = p ^ d[i];
                    q[i] = p ^ (xn && (i % 2 == 1));
                end
                q8   = !xn;
                ones = $countones(q);
                diff = 2 * ones - 8;
                if (cnt_in == 0 || diff == 0) begin
                    s  = {~q8, q8, q8 ? q : ~q};
                    cc = q8 ? cnt_in + diff : cnt_in - diff;
                end else if ((cnt_in > 0 && diff > 0) || (cnt_in < 0 && diff < 0)) begin
                    s  = {1'b1, q8, ~q};
                    cc = cnt_in + (q8 ? 2 : 0) - diff;
                end else begin
                    s  = {1'b0, q8, q};
                    cc = cnt_in + diff - (q8 ? 0 : 2);
                end
                if (cc > 15) cc -= 32;
                else if (cc < -16) cc += 32;
                cnt_out = cc;
            end
        endcase
        return s;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        ce  = 1'b0;
        drive(2'd0, 24'h0, 6'h0, 12'h0);
        #1 rst = 1'b1;
        #1;
        check("rst_out", 32'(tmds_out), 32'({3{10'h354}}));
        check("rst_vld", 32'(out_valid), 32'd0);

        // Reset release, one idle cycle with ce=0, then CTRL codes per lane.
        tick();
        rst = 1'b0;
        drive(2'd0, 24'h0, 6'b11_10_01, 12'h0);
        tick();
        check("ce0_vld", 32'(out_valid), 32'd0);
        check("ce0_out", 32'(tmds_out[9:0]), 32'h354);
        ce = 1'b1;
        tick();
        check("e1_vld", 32'(out_valid), 32'd0);
        check("e1_out", 32'(tmds_out[9:0]), 32'h354);
        tick();
        check("ctl_vld", 32'(out_valid), 32'd1);
        check("ctl_out", 32'(tmds_out), 32'({10'h2AB, 10'h154, 10'h0AB}));

        for (int i = 0; i < N_DIR; i++) begin
            drive(dv_m[i], {3{dv_d[i]}}, 6'h0, 12'h0);
            tick();
            if (i > 0) check($sformatf("vid%0d", i - 1), 32'(tmds_out), 32'({3{dv_e[i-1]}}));
        end
        drive(2'd0, 24'h0, 6'h0, 12'h0);
        tick();
        check($sformatf("vid%0d", N_DIR - 1), 32'(tmds_out), 32'({3{dv_e[N_DIR-1]}}));

        drive(2'd2, 24'h0, 6'h0, 12'h0);
        tick();
        tick();
        check("vguard", 32'(tmds_out), 32'({10'h2CC, 10'h133, 10'h2CC}));

        drive(2'd3, 24'h0, 6'h0, {4'h8, 4'hF, 4'h0});
        tick();
        tick();
        check("terc4_0_f_8", 32'(tmds_out), 32'({10'h2CC, 10'h2C3, 10'h29C}));

        for (int i = 0; i < 16; i++) begin
            n0 = 4'(i);
            n1 = 4'(i + 5);
            n2 = 4'(i + 11);
            drive(2'd3, 24'h0, 6'h0, {n2, n1, n0});
            tick();
            tick();
            check($sformatf("terc4_%0d", i), 32'(tmds_out),
                  32'({terc4_ref[n2], terc4_ref[n1], terc4_ref[n0]}));
        end

        // Random stream against the reference, with a 3-cycle stall midway.
        for (int k = 0; k < NUM_CH; k++) cnt_m[k] = 0;
        e_prev = '0;
        e_out  = '0;
        for (int i = 0; i < N_RND; i++) begin
            if (i == N_RND / 2) begin
                ce = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    drive(2'($urandom_range(0, 3)), 24'($urandom), 6'($urandom), 12'($urandom));
                    tick();
                    check("stall_out", 32'(tmds_out), 32'(e_out));
                end
                check("stall_vld", 32'(out_valid), 32'd1);
                ce = 1'b1;
            end
            r_m = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
            r_d = 24'($urandom);
            r_c = 6'($urandom);
            r_t = 12'($urandom);
            drive(r_m, r_d, r_c, r_t);
            for (int k = 0; k < NUM_CH; k++) begin
                e_cur[10*k +: 10] = ref_sym(k, r_m, r_d[8*k +: 8], r_c[2*k +: 2],
                                            r_t[4*k +: 4], cnt_m[k], cn);
                cnt_m[k] = cn;
            end
            tick();
            if (i > 0) begin
                e_out = e_prev;
                check("rnd", 32'(tmds_out), 32'(e_out));
            end
            e_prev = e_cur;
        end

        // Async reset mid-VIDEO, asserted between edges.
        drive(2'd1, 24'h0, 6'h0, 12'h0);
        tick();
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        check("arst_out", 32'(tmds_out), 32'({3{10'h354}}));
        check("arst_vld", 32'(out_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rs1_vld", 32'(out_valid), 32'd0);
        check("rs1_out", 32'(tmds_out), 32'({3{10'h354}}));
        tick();
        check("rs2_vld", 32'(out_valid), 32'd1);
        check("rs2_out", 32'(tmds_out), 32'({3{10'h100}}));
        tick();
        check("rs3_out", 32'(tmds_out), 32'({3{10'h3FF}}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
